// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        LAP   = 2'd3
    } sw_state_t;

    localparam logic [3:0] DP_NORMAL = 4'b0101;
    localparam logic [3:0] DP_LAP    = 4'b1101;

    // Four BCD digits, [3] is the leftmost display position.
    typedef logic [3:0][3:0] digits_t;

    function automatic logic all_zero(input digits_t d);
        return (d == '0);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stability counter, and a one-cycle
// press pulse on each debounced rising edge.
module btn_debounce #(
    parameter int DB_BITS = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic press
);

    localparam logic [DB_BITS-1:0] CNT_ONE = {{(DB_BITS-1){1'b0}}, 1'b1};

    logic               sync1;
    logic               sync2;
    logic               level;
    logic               level_q;
    logic [DB_BITS-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_q <= 1'b0;
            press   <= 1'b0;
            cnt     <= '0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            level_q <= level;
            press   <= level & ~level_q;
            // Level flips on the 2^DB_BITS-th consecutive disagreeing sample.
            if (sync2 != level) begin
                if (cnt == '1) begin
                    level <= sync2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CNT_ONE;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: debounced start/stop and lap/clear buttons drive the
// counter controls and display digits. Lap freeze is built only with STOPWATCH_LAP_EN.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DB_BITS = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_ss,
    input  logic       btn_lc,
    input  logic       sw_dir,
    input  logic [3:0] d3,
    input  logic [3:0] d2,
    input  logic [3:0] d1,
    input  logic [3:0] d0,
    output logic       go,
    output logic       clr,
    output logic       up,
    output logic [3:0] q3,
    output logic [3:0] q2,
    output logic [3:0] q1,
    output logic [3:0] q0,
    output logic [3:0] dp_out,
    output logic [1:0] state_o
);

    logic      ss;
    logic      lc;
    digits_t   d;
    digits_t   q_r;
    sw_state_t state;
    sw_state_t nxt;
    logic      up_nxt;
    logic      clr_nxt;
    logic      armed;
    logic      armed_nxt;
    logic      term;
    logic      running;
`ifdef STOPWATCH_LAP_EN
    digits_t   lap_r;
    digits_t   lap_nxt;
`endif

    btn_debounce #(.DB_BITS(DB_BITS)) u_db_ss (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_ss),
        .press (ss)
    );

    btn_debounce #(.DB_BITS(DB_BITS)) u_db_lc (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_lc),
        .press (lc)
    );

    assign d       = {d3, d2, d1, d0};
    assign running = (state == RUN) || (state == LAP);
    // Count-down stop only once non-zero digits were seen, so a run started at zero wraps first.
    assign term    = running && armed && !up && all_zero(d);

    always_comb begin
        nxt     = state;
        up_nxt  = up;
        clr_nxt = 1'b0;
`ifdef STOPWATCH_LAP_EN
        lap_nxt = lap_r;
`endif
        case (state)
            IDLE: begin
                if (ss) begin
                    nxt    = RUN;
                    up_nxt = sw_dir;
                end else if (lc) begin
                    clr_nxt = 1'b1;
                end
            end
            RUN: begin
                if (ss || term) begin
                    nxt = PAUSE;
`ifdef STOPWATCH_LAP_EN
                end else if (lc) begin
                    nxt     = LAP;
                    lap_nxt = d;
`endif
                end
            end
`ifdef STOPWATCH_LAP_EN
            LAP: begin
                if (ss || term) begin
                    nxt = PAUSE;
                end else if (lc) begin
                    nxt = RUN;
                end
            end
`endif
            PAUSE: begin
                if (ss) begin
                    nxt = RUN;
                end else if (lc) begin
                    nxt     = IDLE;
                    clr_nxt = 1'b1;
                end
            end
            default: nxt = IDLE;
        endcase

        armed_nxt = armed;
        if ((nxt == IDLE) || term) begin
            armed_nxt = 1'b0;
        end else if (running && !up && !all_zero(d)) begin
            armed_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            state_o <= 2'd0;
            go      <= 1'b0;
            clr     <= 1'b0;
            up      <= 1'b1;
            armed   <= 1'b0;
            q_r     <= '0;
            dp_out  <= DP_NORMAL;
        end else begin
            state   <= nxt;
            state_o <= nxt;
            go      <= (nxt == RUN) || (nxt == LAP);
            clr     <= clr_nxt;
            up      <= up_nxt;
            armed   <= armed_nxt;
`ifdef STOPWATCH_LAP_EN
            q_r     <= (nxt == LAP) ? lap_nxt : d;
            dp_out  <= (nxt == LAP) ? DP_LAP : DP_NORMAL;
`else
            q_r     <= d;
            dp_out  <= DP_NORMAL;
`endif
        end
    end

`ifdef STOPWATCH_LAP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lap_r <= '0;
        end else begin
            lap_r <= lap_nxt;
        end
    end
`endif

    assign {q3, q2, q1, q0} = q_r;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DB_BITS=2 (button stable for 4 cycles).
module tb_stopwatch_ctrl;

`ifdef STOPWATCH_LAP_EN
    localparam bit LAP_ON = 1'b1;
`else
    localparam bit LAP_ON = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       btn_ss;
    logic       btn_lc;
    logic       sw_dir;
    logic [3:0] d3, d2, d1, d0;
    logic       go, clr, up;
    logic [3:0] q3, q2, q1, q0;
    logic [3:0] dp_out;
    logic [1:0] state_o;

    int n_chk;
    int n_fail;

    stopwatch_ctrl #(.DB_BITS(2)) dut (
        .clk     (clk),
        .reset   (reset),
        .btn_ss  (btn_ss),
        .btn_lc  (btn_lc),
        .sw_dir  (sw_dir),
        .d3      (d3),
        .d2      (d2),
        .d1      (d1),
        .d0      (d0),
        .go      (go),
        .clr     (clr),
        .up      (up),
        .q3      (q3),
        .q2      (q2),
        .q1      (q1),
        .q0      (q0),
        .dp_out  (dp_out),
        .state_o (state_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // act: 0 none, 1 start/stop, 2 lap/clear, 3 both together
    typedef struct {
        logic [1:0]  act;
        logic        dir;
        logic [15:0] d;
        logic [1:0]  st;
        logic        go;
        logic        clr;
        logic        up;
        logic [15:0] q;
        logic [3:0]  dp;
    } vec_t;

    vec_t tv[14];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_d(input logic [15:0] v);
        {d3, d2, d1, d0} = v;
    endtask

    // Raw press held until the state edge (N+3 for the pulse, +1 for the FSM).
    task automatic press(input logic s, input logic l);
        btn_ss = s;
        btn_lc = l;
        repeat (8) tick();
    endtask

    task automatic release_btns();
        btn_ss = 1'b0;
        btn_lc = 1'b0;
        repeat (8) tick();
    endtask

    initial begin
        int clr_cnt;
        n_chk  = 0;
        n_fail = 0;

        // start from RUN (entered by the latency sequence), sw_dir=1
        tv[0]  = '{2'd2, 1'b1, 16'h0123, LAP_ON ? 2'd3 : 2'd1, 1'b1, 1'b0, 1'b1,
                   16'h0123, LAP_ON ? 4'b1101 : 4'b0101};
        tv[1]  = '{2'd0, 1'b1, 16'h0456, LAP_ON ? 2'd3 : 2'd1, 1'b1, 1'b0, 1'b1,
                   LAP_ON ? 16'h0123 : 16'h0456, LAP_ON ? 4'b1101 : 4'b0101};
        tv[2]  = '{2'd2, 1'b1, 16'h0789, 2'd1, 1'b1, 1'b0, 1'b1, 16'h0789, 4'b0101};
        tv[3]  = '{2'd1, 1'b1, 16'h0800, 2'd2, 1'b0, 1'b0, 1'b1, 16'h0800, 4'b0101};
        tv[4]  = '{2'd2, 1'b1, 16'h0800, 2'd0, 1'b0, 1'b1, 1'b1, 16'h0800, 4'b0101};
        tv[5]  = '{2'd2, 1'b1, 16'h0800, 2'd0, 1'b0, 1'b1, 1'b1, 16'h0800, 4'b0101};
        tv[6]  = '{2'd1, 1'b0, 16'h0000, 2'd1, 1'b1, 1'b0, 1'b0, 16'h0000, 4'b0101};
        tv[7]  = '{2'd3, 1'b0, 16'h0321, 2'd2, 1'b0, 1'b0, 1'b0, 16'h0321, 4'b0101};
        tv[8]  = '{2'd1, 1'b1, 16'h0321, 2'd1, 1'b1, 1'b0, 1'b0, 16'h0321, 4'b0101};
        tv[9]  = '{2'd1, 1'b1, 16'h0321, 2'd2, 1'b0, 1'b0, 1'b0, 16'h0321, 4'b0101};
        tv[10] = '{2'd2, 1'b1, 16'h0321, 2'd0, 1'b0, 1'b1, 1'b0, 16'h0321, 4'b0101};
        tv[11] = '{2'd1, 1'b1, 16'h0050, 2'd1, 1'b1, 1'b0, 1'b1, 16'h0050, 4'b0101};
        tv[12] = '{2'd1, 1'b0, 16'h0060, 2'd2, 1'b0, 1'b0, 1'b1, 16'h0060, 4'b0101};
        tv[13] = '{2'd2, 1'b0, 16'h0060, 2'd0, 1'b0, 1'b1, 1'b1, 16'h0060, 4'b0101};

        reset  = 1'b1;
        btn_ss = 1'b0;
        btn_lc = 1'b0;
        sw_dir = 1'b1;
        set_d(16'h0000);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", state_o, 2'd0);
        chk("rst_go", go, 1'b0);
        chk("rst_clr", clr, 1'b0);
        chk("rst_up", up, 1'b1);
        chk("rst_q", {q3, q2, q1, q0}, 16'h0000);
        chk("rst_dp", dp_out, 4'b0101);
        reset = 1'b0;
        tick();

        // 3-cycle glitch must not produce a press
        btn_ss = 1'b1;
        repeat (3) tick();
        btn_ss = 1'b0;
        repeat (10) tick();
        chk("glitch_state", state_o, 2'd0);
        chk("glitch_go", go, 1'b0);

        // press latency: go rises on the 8th edge after the raw edge
        btn_ss = 1'b1;
        repeat (7) tick();
        chk("lat_go_edge7", go, 1'b0);
        tick();
        chk("lat_go_edge8", go, 1'b1);
        chk("lat_state", state_o, 2'd1);
        release_btns();

        for (int i = 0; i < 14; i++) begin
            sw_dir = tv[i].dir;
            set_d(tv[i].d);
            if (tv[i].act == 2'd0) begin
                repeat (2) tick();
            end else begin
                press(tv[i].act[0], tv[i].act[1]);
            end
            chk($sformatf("v%0d_state", i), state_o, tv[i].st);
            chk($sformatf("v%0d_go", i), go, tv[i].go);
            chk($sformatf("v%0d_clr", i), clr, tv[i].clr);
            chk($sformatf("v%0d_up", i), up, tv[i].up);
            chk($sformatf("v%0d_q", i), {q3, q2, q1, q0}, tv[i].q);
            chk($sformatf("v%0d_dp", i), dp_out, tv[i].dp);
            if (tv[i].act != 2'd0) release_btns();
        end

        // clear from pause: clr exactly one cycle, go low throughout
        sw_dir = 1'b1;
        set_d(16'h0042);
        press(1'b1, 1'b0);
        release_btns();
        press(1'b1, 1'b0);
        release_btns();
        chk("clr_pause_state", state_o, 2'd2);
        clr_cnt = 0;
        btn_lc = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (clr) clr_cnt++;
            chk($sformatf("clr_go_c%0d", i), go, 1'b0);
        end
        btn_lc = 1'b0;
        chk("clr_pulse_count", clr_cnt, 1);
        chk("clr_state", state_o, 2'd0);
        repeat (8) tick();

        // count-down from zero: wraps, then stops one edge after zero appears
        sw_dir = 1'b0;
        set_d(16'h0000);
        press(1'b1, 1'b0);
        release_btns();
        chk("cd_run_at_zero", go, 1'b1);
        chk("cd_up", up, 1'b0);
        set_d(16'h9599);
        repeat (3) tick();
        chk("cd_wrapped_go", go, 1'b1);
        set_d(16'h0001);
        repeat (2) tick();
        chk("cd_one_state", state_o, 2'd1);
        set_d(16'h0000);
        tick();
        chk("cd_term_state", state_o, 2'd2);
        chk("cd_term_go", go, 1'b0);
        repeat (3) tick();
        chk("cd_stays_paused", state_o, 2'd2);
        press(1'b0, 1'b1);
        release_btns();
        chk("cd_cleared", state_o, 2'd0);

        // asynchronous reset in the middle of a run (LAP when built)
        sw_dir = 1'b1;
        set_d(16'h0123);
        press(1'b1, 1'b0);
        release_btns();
        press(1'b0, 1'b1);
        release_btns();
        set_d(16'h0456);
        tick();
        chk("pre_rst_state", state_o, LAP_ON ? 2'd3 : 2'd1);
        #3 reset = 1'b1;
        #1;
        chk("mid_rst_go", go, 1'b0);
        chk("mid_rst_q", {q3, q2, q1, q0}, 16'h0000);
        chk("mid_rst_up", up, 1'b1);
        chk("mid_rst_state", state_o, 2'd0);
        chk("mid_rst_dp", dp_out, 4'b0101);
        #1 reset = 1'b0;
        tick();
        chk("post_rst_state", state_o, 2'd0);
        chk("post_rst_q", {q3, q2, q1, q0}, 16'h0456);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
